ex_mem_pipe: RTL and testbench

EX_MEM_PIPE -- requirements
Module: ex_mem_pipe

---
 rtl/ex_mem_pipe_pkg.sv | 32 +++
 rtl/ex_mem_pipe_sat_counter.sv | 36 +++
 rtl/ex_mem_pipe.sv | 180 ++++++++++++++++++
 tb/tb_ex_mem_pipe.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_pipe_pkg.sv
// rtl/ex_mem_pipe_pkg.sv - shared constants, action encoding and decode for the EX/MEM register
// Contents:
//   NOP_REGADDR, NOP_ALUOP, ZERO_WORD : values loaded when a stage is squashed
//   STALL_SELF_OFS, STALL_DOWN_OFS    : stall-vector bit offsets relative to STAGE_IDX
//   action_e, decode_action()         : per-cycle action, priority flush > bubble > hold > advance
package ex_mem_pipe_pkg;

  localparam int NOP_REGADDR    = 0;
  localparam int NOP_ALUOP      = 0;
  localparam int ZERO_WORD      = 0;
  localparam int STALL_SELF_OFS = 0;
  localparam int STALL_DOWN_OFS = 1;

  typedef enum logic [1:0] {
    ACT_ADVANCE = 2'd0,
    ACT_HOLD    = 2'd1,
    ACT_BUBBLE  = 2'd2,
    ACT_FLUSH   = 2'd3
  } action_e;

  // A clear own-stall with a set downstream stall is illegal; it still advances
  // and the caller flags the error separately.
  function automatic action_e decode_action(input logic flush,
                                            input logic self_stall,
                                            input logic down_stall);
    if (flush)                         return ACT_FLUSH;
    if (self_stall && !down_stall)     return ACT_BUBBLE;
    if (self_stall)                    return ACT_HOLD;
    return ACT_ADVANCE;
  endfunction

endpackage

// File: rtl/ex_mem_pipe_sat_counter.sv
// rtl/ex_mem_pipe_sat_counter.sv - saturating event counter
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset, clears the count
//   inc   : count one event this cycle
//   count : current count, sticks at all-ones
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/ex_mem_pipe.sv
// rtl/ex_mem_pipe.sv - EX/MEM pipeline register with flush, bubble, hold and bubble counting
// Ports:
//   clk, rst               : clock; asynchronous active-high reset
//   stall, flush           : stall vector (bits STAGE_IDX, STAGE_IDX+1 used); squash
//   ex_*                   : execute-stage results entering the register
//   hilo_i, cnt_i          : multi-cycle accumulator/step from EX, kept while stalled
//   mem_*                  : registered copies of ex_* for the memory stage
//   hilo_o, cnt_o          : accumulator/step returned to EX
//   bubble_cnt, stall_err  : saturating bubble count; sticky illegal-stall flag
module ex_mem_pipe
  import ex_mem_pipe_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REGADDR_W = 5,
  parameter int ALUOP_W   = 8,
  parameter int STALL_W   = 6,
  parameter int STAGE_IDX = 3,
  parameter int CNT_W     = 2,
  parameter int PERF_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [STALL_W-1:0]   stall,
  input  logic                 flush,
  input  logic [REGADDR_W-1:0] ex_wd,
  input  logic                 ex_wreg,
  input  logic [DATA_W-1:0]    ex_wdata,
  input  logic                 ex_whilo,
  input  logic [DATA_W-1:0]    ex_hi,
  input  logic [DATA_W-1:0]    ex_lo,
  input  logic [ALUOP_W-1:0]   ex_aluop,
  input  logic [DATA_W-1:0]    ex_mem_addr,
  input  logic [DATA_W-1:0]    ex_reg2,
  input  logic [2*DATA_W-1:0]  hilo_i,
  input  logic [CNT_W-1:0]     cnt_i,
  output logic [REGADDR_W-1:0] mem_wd,
  output logic                 mem_wreg,
  output logic [DATA_W-1:0]    mem_wdata,
  output logic                 mem_whilo,
  output logic [DATA_W-1:0]    mem_hi,
  output logic [DATA_W-1:0]    mem_lo,
  output logic [ALUOP_W-1:0]   mem_aluop,
  output logic [DATA_W-1:0]    mem_mem_addr,
  output logic [DATA_W-1:0]    mem_reg2,
  output logic [2*DATA_W-1:0]  hilo_o,
  output logic [CNT_W-1:0]     cnt_o,
  output logic [PERF_W-1:0]    bubble_cnt,
  output logic                 stall_err
);

  localparam logic [REGADDR_W-1:0] NOP_WD   = REGADDR_W'(NOP_REGADDR);
  localparam logic [ALUOP_W-1:0]   NOP_OP   = ALUOP_W'(NOP_ALUOP);
  localparam logic [DATA_W-1:0]    ZERO_W   = DATA_W'(ZERO_WORD);

  action_e act;
  logic    self_stall;
  logic    down_stall;
  logic    stall_unused;

  logic [REGADDR_W-1:0] wd_q,    wd_d;
  logic                 wreg_q,  wreg_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic                 whilo_q, whilo_d;
  logic [DATA_W-1:0]    hi_q,    hi_d;
  logic [DATA_W-1:0]    lo_q,    lo_d;
  logic [ALUOP_W-1:0]   aluop_q, aluop_d;
  logic [DATA_W-1:0]    addr_q,  addr_d;
  logic [DATA_W-1:0]    reg2_q,  reg2_d;
  logic [2*DATA_W-1:0]  hilo_q,  hilo_d;
  logic [CNT_W-1:0]     cnt_q,   cnt_d;
  logic                 err_q,   err_d;

  // Only two stall bits matter; the rest are folded here so they read as used.
  assign stall_unused = ^stall;
  assign self_stall   = stall[STAGE_IDX + STALL_SELF_OFS];
  assign down_stall   = stall[STAGE_IDX + STALL_DOWN_OFS];
  assign act          = decode_action(flush, self_stall, down_stall);

  always_comb begin
    wd_d    = wd_q;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    whilo_d = whilo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    aluop_d = aluop_q;
    addr_d  = addr_q;
    reg2_d  = reg2_q;
    hilo_d  = hilo_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (act)
      ACT_FLUSH, ACT_BUBBLE: begin
        wd_d    = NOP_WD;
        wreg_d  = 1'b0;
        wdata_d = ZERO_W;
        whilo_d = 1'b0;
        hi_d    = ZERO_W;
        lo_d    = ZERO_W;
        aluop_d = NOP_OP;
        addr_d  = ZERO_W;
        reg2_d  = ZERO_W;
        // A bubble keeps the multi-cycle op alive; a flush abandons it.
        hilo_d  = (act == ACT_BUBBLE) ? hilo_i : '0;
        cnt_d   = (act == ACT_BUBBLE) ? cnt_i  : '0;
      end
      ACT_HOLD: begin
        hilo_d  = hilo_i;
        cnt_d   = cnt_i;
      end
      default: begin
        wd_d    = ex_wd;
        wreg_d  = ex_wreg;
        wdata_d = ex_wdata;
        whilo_d = ex_whilo;
        hi_d    = ex_hi;
        lo_d    = ex_lo;
        aluop_d = ex_aluop;
        addr_d  = ex_mem_addr;
        reg2_d  = ex_reg2;
        hilo_d  = '0;
        cnt_d   = '0;
        err_d   = err_q | down_stall;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q    <= NOP_WD;
      wreg_q  <= 1'b0;
      wdata_q <= ZERO_W;
      whilo_q <= 1'b0;
      hi_q    <= ZERO_W;
      lo_q    <= ZERO_W;
      aluop_q <= NOP_OP;
      addr_q  <= ZERO_W;
      reg2_q  <= ZERO_W;
      hilo_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      whilo_q <= whilo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      aluop_q <= aluop_d;
      addr_q  <= addr_d;
      reg2_q  <= reg2_d;
      hilo_q  <= hilo_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  sat_counter #(
    .WIDTH(PERF_W)
  ) u_bubble_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (act == ACT_BUBBLE),
    .count(bubble_cnt)
  );

  assign mem_wd       = wd_q;
  assign mem_wreg     = wreg_q;
  assign mem_wdata    = wdata_q;
  assign mem_whilo    = whilo_q;
  assign mem_hi       = hi_q;
  assign mem_lo       = lo_q;
  assign mem_aluop    = aluop_q;
  assign mem_mem_addr = addr_q;
  assign mem_reg2     = reg2_q;
  assign hilo_o       = hilo_q;
  assign cnt_o        = cnt_q;
  assign stall_err    = err_q;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// tb/tb_ex_mem_pipe.sv - self-checking bench for ex_mem_pipe
module tb_ex_mem_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic        ex_whilo;
  logic [31:0] ex_hi, ex_lo, ex_mem_addr, ex_reg2;
  logic [7:0]  ex_aluop;
  logic [63:0] hilo_i;
  logic [1:0]  cnt_i;

  logic [4:0]  mem_wd;
  logic        mem_wreg, mem_whilo, stall_err;
  logic [31:0] mem_wdata, mem_hi, mem_lo, mem_mem_addr, mem_reg2;
  logic [7:0]  mem_aluop;
  logic [63:0] hilo_o;
  logic [1:0]  cnt_o;
  logic [15:0] bubble_cnt;

  logic [4:0]  s_wd;
  logic        s_wreg, s_whilo, s_err;
  logic [31:0] s_wdata, s_hi, s_lo, s_addr, s_reg2;
  logic [7:0]  s_aluop;
  logic [63:0] s_hilo;
  logic [1:0]  s_cnt;
  logic [1:0]  s_bub;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_mem_pipe dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_whilo(ex_whilo),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr),
    .ex_reg2(ex_reg2), .hilo_i(hilo_i), .cnt_i(cnt_i),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_whilo(mem_whilo),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr),
    .mem_reg2(mem_reg2), .hilo_o(hilo_o), .cnt_o(cnt_o),
    .bubble_cnt(bubble_cnt), .stall_err(stall_err)
  );

  ex_mem_pipe #(.PERF_W(2)) dut_sat (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_whilo(ex_whilo),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr),
    .ex_reg2(ex_reg2), .hilo_i(hilo_i), .cnt_i(cnt_i),
    .mem_wd(s_wd), .mem_wreg(s_wreg), .mem_wdata(s_wdata), .mem_whilo(s_whilo),
    .mem_hi(s_hi), .mem_lo(s_lo), .mem_aluop(s_aluop), .mem_mem_addr(s_addr),
    .mem_reg2(s_reg2), .hilo_o(s_hilo), .cnt_o(s_cnt),
    .bubble_cnt(s_bub), .stall_err(s_err)
  );

  typedef struct {
    logic        flush;
    logic [5:0]  stall;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [63:0] hilo;
    logic [1:0]  cnt;
    logic [4:0]  e_wd;
    logic        e_wreg;
    logic [31:0] e_wdata;
    logic [63:0] e_hilo;
    logic [1:0]  e_cnt;
    int          e_bub;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  // Side fields are derived from wdata by maps that send 0 to 0, so a squashed
  // stage expects zero everywhere.
  function automatic logic [31:0] f_hi(input logic [31:0] w);   return {w[15:0], w[31:16]}; endfunction
  function automatic logic [31:0] f_lo(input logic [31:0] w);   return w ^ {w[30:0], 1'b0}; endfunction
  function automatic logic [31:0] f_addr(input logic [31:0] w); return w & 32'hFFFF_FFFC; endfunction
  function automatic logic [31:0] f_reg2(input logic [31:0] w); return {w[7:0], w[31:8]}; endfunction
  function automatic logic [7:0]  f_op(input logic [31:0] w);   return w[7:0] ^ w[15:8]; endfunction

  function automatic vec_t mk(input logic fl, input logic [5:0] st, input logic [4:0] wd,
                              input logic wr, input logic [31:0] wdat, input logic [63:0] hl,
                              input logic [1:0] cn, input logic [4:0] ewd, input logic ewr,
                              input logic [31:0] ewdat, input logic [63:0] ehl,
                              input logic [1:0] ecn, input int ebub, input logic eerr);
    vec_t v;
    v.flush = fl; v.stall = st; v.wd = wd; v.wreg = wr; v.wdata = wdat;
    v.hilo = hl; v.cnt = cn; v.e_wd = ewd; v.e_wreg = ewr; v.e_wdata = ewdat;
    v.e_hilo = ehl; v.e_cnt = ecn; v.e_bub = ebub; v.e_err = eerr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    int   sat;
    @(negedge clk);
    flush = v.flush; stall = v.stall; ex_wd = v.wd; ex_wreg = v.wreg; ex_wdata = v.wdata;
    ex_whilo = v.wreg; ex_hi = f_hi(v.wdata); ex_lo = f_lo(v.wdata);
    ex_mem_addr = f_addr(v.wdata); ex_reg2 = f_reg2(v.wdata); ex_aluop = f_op(v.wdata);
    hilo_i = v.hilo; cnt_i = v.cnt;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    sat = (e.e_bub > 3) ? 3 : e.e_bub;
    chk("mem_wd", 64'(mem_wd), 64'(e.e_wd));
    chk("mem_wreg", 64'(mem_wreg), 64'(e.e_wreg));
    chk("mem_wdata", 64'(mem_wdata), 64'(e.e_wdata));
    chk("mem_whilo", 64'(mem_whilo), 64'(e.e_wreg));
    chk("mem_hi", 64'(mem_hi), 64'(f_hi(e.e_wdata)));
    chk("mem_lo", 64'(mem_lo), 64'(f_lo(e.e_wdata)));
    chk("mem_aluop", 64'(mem_aluop), 64'(f_op(e.e_wdata)));
    chk("mem_mem_addr", 64'(mem_mem_addr), 64'(f_addr(e.e_wdata)));
    chk("mem_reg2", 64'(mem_reg2), 64'(f_reg2(e.e_wdata)));
    chk("hilo_o", hilo_o, e.e_hilo);
    chk("cnt_o", 64'(cnt_o), 64'(e.e_cnt));
    chk("bubble_cnt", 64'(bubble_cnt), 64'(e.e_bub));
    chk("stall_err", 64'(stall_err), 64'(e.e_err));
    chk("bubble_cnt_sat", 64'(s_bub), 64'(sat));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wd"}, 64'(mem_wd), 64'd0);
    chk({tag, "_wreg"}, 64'(mem_wreg), 64'd0);
    chk({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, "_whilo"}, 64'(mem_whilo), 64'd0);
    chk({tag, "_hi_lo"}, {mem_hi, mem_lo}, 64'd0);
    chk({tag, "_aluop"}, 64'(mem_aluop), 64'd0);
    chk({tag, "_addr_reg2"}, {mem_mem_addr, mem_reg2}, 64'd0);
    chk({tag, "_hilo"}, hilo_o, 64'd0);
    chk({tag, "_cnt"}, 64'(cnt_o), 64'd0);
    chk({tag, "_bubble"}, 64'(bubble_cnt), 64'd0);
    chk({tag, "_err"}, 64'(stall_err), 64'd0);
    chk({tag, "_sat_bubble"}, 64'(s_bub), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; stall = '0; ex_wd = 5'd31; ex_wreg = 1'b1; ex_wdata = 32'hFFFF_FFFF;
    ex_whilo = 1'b1; ex_hi = '1; ex_lo = '1; ex_aluop = '1; ex_mem_addr = '1; ex_reg2 = '1;
    hilo_i = '1; cnt_i = '1;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    //            fl  stall        wd  wr wdata          hilo            cn  ewd ewr e_wdata        e_hilo          ecn bub err
    vecs.push_back(mk(0, 6'b000000, 3, 1, 32'hDEADBEEF, 64'hAA,          2,  3, 1, 32'hDEADBEEF, 64'h0,          0, 0, 0));
    vecs.push_back(mk(0, 6'b001000, 7, 1, 32'h11111111, 64'h1_00000002,  1,  0, 0, 32'h0,        64'h1_00000002, 1, 1, 0));
    vecs.push_back(mk(0, 6'b000000, 4, 1, 32'h12345678, 64'h5,           3,  4, 1, 32'h12345678, 64'h0,          0, 1, 0));
    vecs.push_back(mk(0, 6'b011000, 8, 0, 32'hCAFE0001, 64'h31,          1,  4, 1, 32'h12345678, 64'h31,         1, 1, 0));
    vecs.push_back(mk(0, 6'b011000, 9, 0, 32'hCAFE0002, 64'h32,          2,  4, 1, 32'h12345678, 64'h32,         2, 1, 0));
    vecs.push_back(mk(0, 6'b011000,10, 0, 32'hCAFE0003, 64'h33,          3,  4, 1, 32'h12345678, 64'h33,         3, 1, 0));
    vecs.push_back(mk(0, 6'b000000, 9, 0, 32'hA5A5A5A5, 64'h44,          1,  9, 0, 32'hA5A5A5A5, 64'h0,          0, 1, 0));
    vecs.push_back(mk(1, 6'b001000,11, 1, 32'h00000077, 64'h55,          2,  0, 0, 32'h0,        64'h0,          0, 1, 0));
    vecs.push_back(mk(0, 6'b100111, 2, 1, 32'h0F0F0F0F, 64'h66,          3,  2, 1, 32'h0F0F0F0F, 64'h0,          0, 1, 0));
    vecs.push_back(mk(1, 6'b011000,12, 1, 32'h13579BDF, 64'h77,          1,  0, 0, 32'h0,        64'h0,          0, 1, 0));
    vecs.push_back(mk(1, 6'b010000,13, 1, 32'h2468ACE0, 64'h78,          1,  0, 0, 32'h0,        64'h0,          0, 1, 0));
    vecs.push_back(mk(0, 6'b010000, 5, 1, 32'hBEEF0001, 64'h88,          2,  5, 1, 32'hBEEF0001, 64'h0,          0, 1, 1));
    vecs.push_back(mk(0, 6'b101000,14, 1, 32'h99999999, 64'h2_00000001,  3,  0, 0, 32'h0,        64'h2_00000001, 3, 2, 1));
    vecs.push_back(mk(0, 6'b000000,15, 1, 32'h80000001, 64'hAB,          1, 15, 1, 32'h80000001, 64'h0,          0, 2, 1));
    for (int i = 0; i < 5; i++) begin
      vecs.push_back(mk(0, 6'b001000, 5'(i), 1, 32'h100 + i, 64'(i) + 64'h900, 2'(i),
                        0, 0, 32'h0, 64'(i) + 64'h900, 2'(i), 3 + i, 1));
    end
    vecs.push_back(mk(0, 6'b000000, 6, 1, 32'h600D600D, 64'h1, 1, 6, 1, 32'h600D600D, 64'h0, 0, 7, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
    end

    // Asynchronous reset between edges while mem_wreg is high.
    #3;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of a hold discards the held word.
    apply(mk(0, 6'b000000, 1, 1, 32'h00000011, 64'h0,  0, 1, 1, 32'h00000011, 64'h0,  0, 0, 0));
    apply(mk(0, 6'b011000, 2, 1, 32'h00000099, 64'h99, 3, 1, 1, 32'h00000011, 64'h99, 3, 0, 0));
    #2;
    rst = 1'b1;
    #1;
    chk("hold_rst_wdata", 64'(mem_wdata), 64'd0);
    chk("hold_rst_hilo", hilo_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    apply(mk(0, 6'b000000, 3, 1, 32'h00000022, 64'h5, 1, 3, 1, 32'h00000022, 64'h0, 0, 0, 0));
    apply(mk(0, 6'b001000, 4, 1, 32'h00000033, 64'h6, 2, 0, 0, 32'h0,        64'h6, 2, 1, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
